// File: rtl/prbs_checker.sv
// prbs_checker
//   Self-synchronising parallel PRBS checker. While hunting it loads its LFSR
//   state straight from the received bits; once LOCK_COUNT consecutive words
//   match the prediction it free-runs the local LFSR and counts errors.
//   Optional build macro: PRBS_CHK_FIRST_ERR_EN adds capture of the first
//   errored word (expected and received values).
// Ports
//   clk, rst        clock, synchronous active-high reset
//   data_in         received word, MSB is the oldest bit
//   data_valid      data_in is valid this cycle
//   clear           synchronous counter clear (lock state untouched)
//   locked          checker is locked
//   err_word        1-cycle pulse: previous valid locked word was errored
//   word_count      valid words checked while locked (saturating)
//   err_word_count  errored words while locked (saturating)
//   bit_err_count   bit errors while locked (saturating)
//   first_err_*     (optional) first errored word after rst/clear

module prbs_checker_lfsr #(
    parameter int                    LFSR_WIDTH = 31,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 31'h10000001,
    parameter int                    DATA_WIDTH = 8
) (
    input  logic [LFSR_WIDTH-1:0] state_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [LFSR_WIDTH-1:0] state_out,
    output logic [DATA_WIDTH-1:0] data_out
);
    // Fibonacci LFSR stepped DATA_WIDTH times, MSB of the word first.
    logic [LFSR_WIDTH-1:0] s;
    logic                  fb;

    always_comb begin
        s        = state_in;
        fb       = 1'b0;
        data_out = '0;
        for (int unsigned k = 0; k < DATA_WIDTH; k++) begin
            fb = s[LFSR_WIDTH-1] ^ data_in[DATA_WIDTH-1-k];
            for (int unsigned j = 1; j < LFSR_WIDTH; j++) begin
                if (LFSR_POLY[j]) fb = fb ^ s[j-1];
            end
            s = {s[LFSR_WIDTH-2:0], fb};
            data_out[DATA_WIDTH-1-k] = fb;
        end
        state_out = s;
    end
endmodule

module prbs_checker #(
    parameter int                    LFSR_WIDTH   = 31,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 31'h10000001,
    parameter int                    INVERT       = 1,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    LOCK_COUNT   = 16,
    parameter int                    UNLOCK_COUNT = 4,
    parameter int                    CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    input  logic                  clear,
    output logic                  locked,
    output logic                  err_word,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [CNT_WIDTH-1:0]  err_word_count,
    output logic [CNT_WIDTH-1:0]  bit_err_count
`ifdef PRBS_CHK_FIRST_ERR_EN
    ,
    output logic                  first_err_valid,
    output logic [DATA_WIDTH-1:0] first_err_exp,
    output logic [DATA_WIDTH-1:0] first_err_rcv
`endif
);
    localparam int   FILL_WORDS = (LFSR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int   FILL_W     = $clog2(FILL_WORDS + 1);
    localparam int   GOOD_W     = $clog2(LOCK_COUNT + 1);
    localparam int   BAD_W      = $clog2(UNLOCK_COUNT + 1);
    localparam int   NERR_W     = $clog2(DATA_WIDTH + 1);
    localparam int   SUM_W      = CNT_WIDTH + 1;
    localparam logic INV_BIT    = (INVERT != 0);

    typedef enum logic [1:0] {S_FILL = 2'd0, S_HUNT = 2'd1, S_LOCKED = 2'd2} fsm_t;

    fsm_t                  fsm_q;
    logic [LFSR_WIDTH-1:0] state_q;
    logic [FILL_W-1:0]     fill_q;
    logic [GOOD_W-1:0]     good_q;
    logic [BAD_W-1:0]      bad_q;
    logic                  locked_q, err_word_q;
    logic [CNT_WIDTH-1:0]  wc_q, ewc_q, bec_q;

    logic [LFSR_WIDTH-1:0] lfsr_state;
    logic [DATA_WIDTH-1:0] lfsr_data, exp_w, rx_word, diff;
    logic [LFSR_WIDTH-1:0] shift_d;
    logic [NERR_W-1:0]     nerr;
    logic                  word_err, state_degen;
    logic [GOOD_W-1:0]     good_d;
    logic [BAD_W-1:0]      bad_d;
    logic [CNT_WIDTH-1:0]  wc_d, ewc_d, bec_d;
    logic [SUM_W-1:0]      bec_sum;

    prbs_checker_lfsr #(
        .LFSR_WIDTH (LFSR_WIDTH),
        .LFSR_POLY  (LFSR_POLY),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lfsr (
        .state_in  (state_q),
        .data_in   ('0),
        .state_out (lfsr_state),
        .data_out  (lfsr_data)
    );

    assign exp_w   = lfsr_data ^ {DATA_WIDTH{INV_BIT}};
    assign rx_word = data_in ^ {DATA_WIDTH{INV_BIT}};
    assign diff    = exp_w ^ data_in;

    // Receive shift: the newest received bits become the LFSR state.
    if (DATA_WIDTH < LFSR_WIDTH) begin : g_shift
        assign shift_d = {state_q[LFSR_WIDTH-DATA_WIDTH-1:0], rx_word};
    end else begin : g_load
        assign shift_d = rx_word[LFSR_WIDTH-1:0];
    end

    always_comb begin
        nerr = '0;
        for (int unsigned k = 0; k < DATA_WIDTH; k++) nerr = nerr + NERR_W'(diff[k]);
    end

    assign word_err    = (nerr != '0);
    // state_q holds de-inverted bits, so the degenerate state is all-zero for
    // both polarities; a matching word there is not allowed to build a run.
    assign state_degen = (state_q == '0);
    assign good_d      = good_q + 1'b1;
    assign bad_d       = bad_q + 1'b1;
    assign wc_d        = (&wc_q)  ? wc_q  : wc_q + 1'b1;
    assign ewc_d       = (&ewc_q) ? ewc_q : ewc_q + 1'b1;
    assign bec_sum     = {1'b0, bec_q} + SUM_W'(nerr);
    assign bec_d       = bec_sum[CNT_WIDTH] ? '1 : bec_sum[CNT_WIDTH-1:0];

`ifdef PRBS_CHK_FIRST_ERR_EN
    logic                  fe_valid_q;
    logic [DATA_WIDTH-1:0] fe_exp_q, fe_rcv_q;
    assign first_err_valid = fe_valid_q;
    assign first_err_exp   = fe_exp_q;
    assign first_err_rcv   = fe_rcv_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= S_FILL;
            state_q    <= '0;
            fill_q     <= '0;
            good_q     <= '0;
            bad_q      <= '0;
            locked_q   <= 1'b0;
            err_word_q <= 1'b0;
            wc_q       <= '0;
            ewc_q      <= '0;
            bec_q      <= '0;
`ifdef PRBS_CHK_FIRST_ERR_EN
            fe_valid_q <= 1'b0;
            fe_exp_q   <= '0;
            fe_rcv_q   <= '0;
`endif
        end else begin
            err_word_q <= 1'b0;
            if (data_valid) begin
                unique case (fsm_q)
                    S_FILL: begin
                        state_q <= shift_d;
                        fill_q  <= fill_q + 1'b1;
                        if (fill_q == FILL_W'(FILL_WORDS - 1)) fsm_q <= S_HUNT;
                    end
                    S_HUNT: begin
                        state_q <= shift_d;
                        if (word_err || state_degen) begin
                            good_q <= '0;
                        end else begin
                            good_q <= good_d;
                            if (good_d == GOOD_W'(LOCK_COUNT)) begin
                                fsm_q    <= S_LOCKED;
                                locked_q <= 1'b1;
                                bad_q    <= '0;
                            end
                        end
                    end
                    S_LOCKED: begin
                        state_q <= lfsr_state;
                        wc_q    <= wc_d;
                        if (word_err) begin
                            err_word_q <= 1'b1;
                            ewc_q      <= ewc_d;
                            bec_q      <= bec_d;
                            bad_q      <= bad_d;
`ifdef PRBS_CHK_FIRST_ERR_EN
                            if (!fe_valid_q) begin
                                fe_valid_q <= 1'b1;
                                fe_exp_q   <= exp_w;
                                fe_rcv_q   <= data_in;
                            end
`endif
                            if (bad_d == BAD_W'(UNLOCK_COUNT)) begin
                                fsm_q    <= S_HUNT;
                                locked_q <= 1'b0;
                                good_q   <= '0;
                            end
                        end else begin
                            bad_q <= '0;
                        end
                    end
                    default: fsm_q <= S_FILL;
                endcase
            end
            // Later assignments win: clear discards this word's counter update.
            if (clear) begin
                wc_q  <= '0;
                ewc_q <= '0;
                bec_q <= '0;
`ifdef PRBS_CHK_FIRST_ERR_EN
                fe_valid_q <= 1'b0;
                fe_exp_q   <= '0;
                fe_rcv_q   <= '0;
`endif
            end
        end
    end

    assign locked         = locked_q;
    assign err_word       = err_word_q;
    assign word_count     = wc_q;
    assign err_word_count = ewc_q;
    assign bit_err_count  = bec_q;
endmodule

// File: tb/tb_prbs_checker.sv
module tb_prbs_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // index 0: PRBS7 (8-bit counters), index 1: PRBS31 inverted
    logic       rst7, v7, c7, lk7, ew7;
    logic [7:0] d7, wc7, ewc7, bec7;
    logic       rst31, v31, c31, lk31, ew31;
    logic [7:0] d31;
    logic [31:0] wc31, ewc31, bec31;
`ifdef PRBS_CHK_FIRST_ERR_EN
    logic       fv7, fv31;
    logic [7:0] fe7, fr7, fe31, fr31;
`endif

    prbs_checker #(.LFSR_WIDTH(7), .LFSR_POLY(7'h41), .INVERT(0), .DATA_WIDTH(8),
                   .LOCK_COUNT(16), .UNLOCK_COUNT(4), .CNT_WIDTH(8)) u7 (
        .clk(clk), .rst(rst7), .data_in(d7), .data_valid(v7), .clear(c7),
        .locked(lk7), .err_word(ew7), .word_count(wc7), .err_word_count(ewc7),
        .bit_err_count(bec7)
`ifdef PRBS_CHK_FIRST_ERR_EN
        , .first_err_valid(fv7), .first_err_exp(fe7), .first_err_rcv(fr7)
`endif
    );

    prbs_checker #(.LFSR_WIDTH(31), .LFSR_POLY(31'h10000001), .INVERT(1), .DATA_WIDTH(8),
                   .LOCK_COUNT(16), .UNLOCK_COUNT(4), .CNT_WIDTH(32)) u31 (
        .clk(clk), .rst(rst31), .data_in(d31), .data_valid(v31), .clear(c31),
        .locked(lk31), .err_word(ew31), .word_count(wc31), .err_word_count(ewc31),
        .bit_err_count(bec31)
`ifdef PRBS_CHK_FIRST_ERR_EN
        , .first_err_valid(fv31), .first_err_exp(fe31), .first_err_rcv(fr31)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference model: bit-sequence view. Bit n of a PRBS obeys
    // b[n] = b[n-W] ^ b[n-TAP]; hist keeps recent bits, bit k-1 = k steps ago.
    int              W_[2]    = '{7, 31};
    int              TAP_[2]  = '{6, 28};
    int              INV_[2]  = '{0, 1};
    int              FILLW[2] = '{1, 4};
    longint unsigned CMAX[2]  = '{64'd255, 64'hFFFF_FFFF};

    longint unsigned gen[2];
    longint unsigned hist[2];
    int              mode[2];   // 0 fill, 1 hunt, 2 locked
    int              fillc[2], good[2], bad[2];
    longint unsigned wc[2], ewc[2], bec[2];
    bit              e_err[2];
    bit              fval[2];
    logic [7:0]      fexp[2], frcv[2];

    function automatic bit next_bit(input longint unsigned h, input int m);
        return h[W_[m]-1] ^ h[TAP_[m]-1];
    endfunction

    task automatic model_reset(input int m);
        mode[m] = 0; fillc[m] = 0; good[m] = 0; bad[m] = 0; hist[m] = 0;
        wc[m] = 0; ewc[m] = 0; bec[m] = 0; e_err[m] = 0;
        fval[m] = 0; fexp[m] = 0; frcv[m] = 0;
    endtask

    task automatic model_step(input int m, input logic rr, input logic vv,
                              input logic [7:0] dd, input logic cc);
        longint unsigned p, h;
        logic [7:0] ex;
        int nerr;
        bit b, ew, invb;
        if (rr) begin
            model_reset(m);
            return;
        end
        ew   = 0;
        invb = (INV_[m] != 0);
        if (vv) begin
            p = hist[m];
            for (int k = 0; k < 8; k++) begin
                b = next_bit(p, m);
                p = (p << 1) | longint'(b);
                ex[7-k] = b ^ invb;
            end
            nerr = $countones(ex ^ dd);
            h = hist[m];
            for (int k = 0; k < 8; k++) h = (h << 1) | longint'(dd[7-k] ^ invb);
            case (mode[m])
                0: begin
                    hist[m] = h;
                    fillc[m]++;
                    if (fillc[m] == FILLW[m]) mode[m] = 1;
                end
                1: begin
                    if (nerr == 0 && (hist[m] & ((64'd1 << W_[m]) - 1)) != 0) good[m]++;
                    else good[m] = 0;
                    hist[m] = h;
                    if (good[m] == 16) begin mode[m] = 2; bad[m] = 0; end
                end
                default: begin
                    hist[m] = p;
                    if (wc[m] < CMAX[m]) wc[m]++;
                    if (nerr != 0) begin
                        ew = 1;
                        bad[m]++;
                        if (ewc[m] < CMAX[m]) ewc[m]++;
                        bec[m] = (bec[m] + nerr > CMAX[m]) ? CMAX[m] : bec[m] + nerr;
                        if (!fval[m]) begin fval[m] = 1; fexp[m] = ex; frcv[m] = dd; end
                        if (bad[m] == 4) begin mode[m] = 1; good[m] = 0; end
                    end else begin
                        bad[m] = 0;
                    end
                end
            endcase
        end
        if (cc) begin
            wc[m] = 0; ewc[m] = 0; bec[m] = 0;
            fval[m] = 0; fexp[m] = 0; frcv[m] = 0;
        end
        e_err[m] = ew;
    endtask

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_all();
        chk("u7.locked",   64'(lk7),  64'(mode[0] == 2));
        chk("u7.err_word", 64'(ew7),  64'(e_err[0]));
        chk("u7.wc",       64'(wc7),  wc[0]);
        chk("u7.ewc",      64'(ewc7), ewc[0]);
        chk("u7.bec",      64'(bec7), bec[0]);
        chk("u31.locked",   64'(lk31),  64'(mode[1] == 2));
        chk("u31.err_word", 64'(ew31),  64'(e_err[1]));
        chk("u31.wc",       64'(wc31),  wc[1]);
        chk("u31.ewc",      64'(ewc31), ewc[1]);
        chk("u31.bec",      64'(bec31), bec[1]);
`ifdef PRBS_CHK_FIRST_ERR_EN
        chk("u7.fe_valid", 64'(fv7), 64'(fval[0]));
        chk("u7.fe_exp",   64'(fe7), 64'(fexp[0]));
        chk("u7.fe_rcv",   64'(fr7), 64'(frcv[0]));
        chk("u31.fe_valid", 64'(fv31), 64'(fval[1]));
        chk("u31.fe_exp",   64'(fe31), 64'(fexp[1]));
        chk("u31.fe_rcv",   64'(fr31), 64'(frcv[1]));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, rst7, v7, d7, c7);
        model_step(1, rst31, v31, d31, c31);
        #1;
        check_all();
    endtask

    task automatic gen_word(input int m, output logic [7:0] w);
        bit b;
        for (int k = 0; k < 8; k++) begin
            b = next_bit(gen[m], m);
            gen[m] = (gen[m] << 1) | longint'(b);
            w[7-k] = b ^ (INV_[m] != 0);
        end
    endtask

    task automatic send_raw(input int m, input bit vld, input logic [7:0] d, input bit clr);
        if (m == 0) begin v7 = vld; d7 = d; c7 = clr; end
        else        begin v31 = vld; d31 = d; c31 = clr; end
        tick();
        v7 = 0; c7 = 0; v31 = 0; c31 = 0;
        d7 = 8'($urandom); d31 = 8'($urandom);
    endtask

    task automatic send(input int m, input bit vld, input logic [7:0] mask, input bit clr);
        logic [7:0] w;
        w = 8'($urandom);
        if (vld) begin
            gen_word(m, w);
            w = w ^ mask;
        end
        send_raw(m, vld, w, clr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n, nv;
        bit vld;
        logic [7:0] mask;
        gen[0] = 64'h7F;
        gen[1] = longint'($urandom_range(1, 32'h7FFF_FFFF));
        model_reset(0); model_reset(1);
        rst7 = 1; rst31 = 1; v7 = 0; v31 = 0; c7 = 0; c31 = 0; d7 = 0; d31 = 0;
        tick(); tick();
        chk("reset.locked7", 64'(lk7), 64'd0);
        chk("reset.wc31", 64'(wc31), 64'd0);
        rst7 = 0; rst31 = 0;

        // all-zero stream (degenerate state) must never lock
        for (int i = 0; i < 24; i++) send_raw(0, 1, 8'h00, 0);
        chk("degen.no_lock", 64'(lk7), 64'd0);
        rst7 = 1; tick(); rst7 = 0;

        // PRBS7: 1 fill word + 16 good words
        n = 0;
        for (int i = 0; i < 40; i++) begin
            send(0, 1, 8'h00, 0); n++;
            if (lk7 === 1'b1) break;
        end
        chk("t1.lock_words", 64'(n), 64'd17);
        for (int i = 0; i < 100; i++) send(0, 1, 8'h00, 0);
        chk("t1.wc100", 64'(wc7), 64'd100);
        chk("t1.ewc0", 64'(ewc7), 64'd0);
        chk("t1.bec0", 64'(bec7), 64'd0);

        // single 2-bit error
        send(0, 1, 8'h05, 0);
        chk("t2.err_pulse", 64'(ew7), 64'd1);
        for (int i = 0; i < 5; i++) send(0, 1, 8'h00, 0);
        chk("t2.ewc", 64'(ewc7), 64'd1);
        chk("t2.bec", 64'(bec7), 64'd2);
        chk("t2.locked", 64'(lk7), 64'd1);

        // 4 inverted words force unlock, then relock after 16
        for (int i = 0; i < 3; i++) send(0, 1, 8'hFF, 0);
        chk("t3.still_locked", 64'(lk7), 64'd1);
        send(0, 1, 8'hFF, 0);
        chk("t3.unlocked", 64'(lk7), 64'd0);
        chk("t3.bec", 64'(bec7), 64'd34);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            send(0, 1, 8'h00, 0); n++;
            if (lk7 === 1'b1) break;
        end
        chk("t3.relock_words", 64'(n), 64'd16);

        // clear coincident with an errored word
        send(0, 1, 8'h01, 1);
        chk("t5.err_pulse", 64'(ew7), 64'd1);
        chk("t5.wc_clr", 64'(wc7), 64'd0);
        chk("t5.bec_clr", 64'(bec7), 64'd0);
        send(0, 1, 8'h01, 0); send(0, 1, 8'h01, 0);
        chk("t5.locked_bad3", 64'(lk7), 64'd1);
        send(0, 1, 8'h01, 0);
        chk("t5.unlock_bad4", 64'(lk7), 64'd0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            send(0, 1, 8'h00, 0); n++;
            if (lk7 === 1'b1) break;
        end
        chk("t5.relock_words", 64'(n), 64'd16);

        // saturation of 8-bit counters, first-error capture
        send(0, 1, 8'h00, 1);
        for (int i = 0; i < 90; i++) begin
            for (int j = 0; j < 3; j++) send(0, 1, 8'h80, 0);
            send(0, 1, 8'h00, 0);
        end
        chk("t6.wc_sat", 64'(wc7), 64'd255);
        chk("t6.ewc_sat", 64'(ewc7), 64'd255);
        chk("t6.bec_sat", 64'(bec7), 64'd255);
        chk("t6.locked", 64'(lk7), 64'd1);
`ifdef PRBS_CHK_FIRST_ERR_EN
        chk("t6.fe_valid", 64'(fv7), 64'd1);
        chk("t6.fe_rcv_delta", 64'(fr7 ^ fexp[0]), 64'h80);
        send(0, 1, 8'h00, 1);
        chk("t6.fe_cleared", 64'(fv7), 64'd0);
`endif

        // PRBS7 random traffic
        for (int i = 0; i < 300; i++) begin
            vld  = ($urandom_range(0, 3) != 0);
            mask = ($urandom_range(0, 7) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            send(0, vld, mask, ($urandom_range(0, 49) == 0));
        end

        // PRBS31 inverted, valid toggled pseudo-randomly: 4 fill + 16 words
        n = 0;
        for (int i = 0; i < 200; i++) begin
            vld = 1'($urandom_range(0, 1));
            send(1, vld, 8'h00, 0);
            if (vld) n++;
            if (lk31 === 1'b1) break;
        end
        chk("t4.lock_words", 64'(n), 64'd20);
        nv = 0;
        for (int i = 0; i < 60; i++) begin
            vld = 1'($urandom_range(0, 1));
            send(1, vld, 8'h00, 0);
            if (vld) nv++;
        end
        chk("t4.wc_valid_only", 64'(wc31), 64'(nv));
        for (int i = 0; i < 300; i++) begin
            vld  = 1'($urandom_range(0, 1));
            mask = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
            send(1, vld, mask, ($urandom_range(0, 59) == 0));
        end

        // rst mid-LOCKED on PRBS31
        for (int i = 0; i < 100; i++) begin
            send(1, 1, 8'h00, 0);
            if (lk31 === 1'b1) break;
        end
        chk("t5b.locked_before", 64'(lk31), 64'd1);
        rst31 = 1;
        send(1, 1, 8'h00, 0);
        rst31 = 0;
        chk("t5b.rst_unlock", 64'(lk31), 64'd0);
        chk("t5b.rst_wc", 64'(wc31), 64'd0);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            vld = 1'($urandom_range(0, 1));
            send(1, vld, 8'h00, 0);
            if (vld) n++;
            if (lk31 === 1'b1) break;
        end
        chk("t5b.relock_words", 64'(n), 64'd20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
Sequential PRBS checker that sits directly downstream of the parallel combinational lfsr generator stage. It consumes the generated (or looped-back) parallel data stream, self-synchronises its own LFSR state from the received bits, and then free-runs a local lfsr instance to predict each word. It reports lock status, counts word and bit errors, and feeds the link-test status registers.

Parameters:
LFSR_WIDTH, 31, LFSR width; passed to the internal lfsr instance.
LFSR_POLY, 31'h10000001, polynomial with the x^LFSR_WIDTH term suppressed; Fibonacci configuration, no reverse.
INVERT, 1, 1 = the expected data is the inverted LFSR output (PRBS15/23/29/31 style).
DATA_WIDTH, 8, bits per word; data_in[DATA_WIDTH-1] is the oldest bit in time.
LOCK_COUNT, 16, consecutive error-free words required in HUNT before entering LOCKED.
UNLOCK_COUNT, 4, consecutive errored words in LOCKED that force a return to HUNT.
CNT_WIDTH, 32, width of the word, error-word and bit-error counters.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
data_in  input  DATA_WIDTH  received word
data_valid  input  1  data_in is valid this cycle
clear  input  1  synchronous counter clear; does not affect lock state
locked  output  1  checker is in LOCKED
err_word  output  1  one-cycle pulse: previous valid word had at least one bit error (LOCKED only)
word_count  output  CNT_WIDTH  valid words checked while LOCKED
err_word_count  output  CNT_WIDTH  errored words while LOCKED
bit_err_count  output  CNT_WIDTH  total bit errors while LOCKED

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: all outputs 0; state register 0; FSM in FILL; fill, good-run and bad-run counters 0.
- Prediction: an internal lfsr instance uses state_in = state_reg and data_in = 0. exp = lfsr data_out ^ {DATA_WIDTH{INVERT}}. diff = exp ^ data_in. nerr = popcount(diff).
- Receive shift (applies in FILL and HUNT): if DATA_WIDTH < LFSR_WIDTH, state_reg <= {state_reg[LFSR_WIDTH-DATA_WIDTH-1:0], data_in ^ {INVERT}}. Otherwise state_reg <= (data_in ^ {INVERT})[LFSR_WIDTH-1:0].
- LOCKED: state_reg <= lfsr state_out. The checker free-runs, so received errors do not corrupt the prediction.
- FSM advances only on data_valid. Idle cycles change nothing; err_word is 0 on idle cycles.
- FILL: apply the receive shift. After ceil(LFSR_WIDTH/DATA_WIDTH) valid words, go to HUNT. No comparison is made in FILL.
- HUNT: compare, then apply the receive shift.
  - nerr == 0: good_run + 1.
  - nerr != 0: good_run = 0.
  - When good_run reaches LOCK_COUNT, go to LOCKED and clear bad_run. The entering word is not counted.
- LOCKED: word_count + 1.
  - nerr != 0: err_word_count + 1, bit_err_count + nerr, bad_run + 1, err_word pulses.
  - nerr == 0: bad_run = 0.
  - When bad_run reaches UNLOCK_COUNT, go to HUNT (good_run = 0, locked drops). The state is not refilled; self-sync resumes from the next word.
- Latency: all outputs are registered and reflect word N one cycle after its data_valid.
- Counters saturate at all-ones and never wrap. bit_err_count saturates if the addition would overflow.
- clear has priority over a coincident word: the counters go to 0 and that word's contribution is discarded. Lock and run tracking still process the word.
- rst mid-stream: the next cycle equals the reset state; the checker restarts in FILL.
- All-zero received state (non-inverted) or all-ones (inverted) is a degenerate LFSR state; the checker never locks on it because a PRBS stream does not produce it.

Optional Feature:
PRBS_CHK_FIRST_ERR_EN
- With the macro defined, add outputs first_err_valid (1), first_err_exp (DATA_WIDTH) and first_err_rcv (DATA_WIDTH).
  - On the first errored LOCKED word after rst or clear, capture exp and data_in and set first_err_valid.
  - Hold the captured values until rst or clear.
  - All three outputs reset to 0.
- Without the macro, these ports and registers do not exist.

Test Plan:
1. PRBS7 (LFSR_WIDTH=7, LFSR_POLY=7'h41, INVERT=0, DATA_WIDTH=8, LOCK_COUNT=16) fed from the lfsr generator, seed 7'h7F, continuous valid -> locked rises after 1 fill word + 16 words, plus 1 cycle; after 100 further words word_count=100 and both error counts are 0.
2. Locked PRBS7 stream, data_in ^= 8'h05 on one word -> err_word pulses once, err_word_count=1, bit_err_count=2; the following words are clean and locked stays 1.
3. Locked PRBS7, UNLOCK_COUNT=4, invert 4 consecutive words -> bit_err_count=32, locked=0 one cycle after the 4th word; clean stream resumes -> relock after 16 good words.
4. PRBS31 INVERT=1, data_valid toggled 1-0-1 pseudo-randomly -> lock after 4 fill + 16 valid words; idle cycles leave the counters unchanged.
5. clear asserted on the same cycle as an errored LOCKED word -> all counters 0 next cycle; err_word still pulses; bad_run is still 1 (verified by 3 more errored words forcing unlock). Separately, rst mid-LOCKED -> locked=0 next cycle and relock takes fill + 16 words.
6. With PRBS_CHK_FIRST_ERR_EN, err_word_count preloaded near all-ones by forcing errors -> counter holds at 32'hFFFFFFFF; first_err_exp/first_err_rcv hold the first error (e.g. rcv = exp ^ 8'h80) until clear.
